scr1_dp_memory_ext: RTL and testbench
=====================================

SCR1_DP_MEMORY_EXT -- requirements
Module: scr1_dp_memory_ext

Interface
REQ-001 SHALL have parameter SCR1_WIDTH, default 32, data word width in bits; multiple of 8, range 8..128.
REQ-002 SHALL have parameter SCR1_SIZE, default 65536, memory size in bytes; power of two, at least 2*SCR1_NBYTES.
REQ-003 SHALL have parameter SCR1_NBYTES, default SCR1_WIDTH/8, byte lanes per word.
REQ-004 SHALL have parameter SCR1_RD_LATENCY, default 1, read latency in cycles; legal values 1 or 2.
REQ-005 SHALL have parameter SCR1_WRITE_FIRST, default 0, collision mode: 0 = read-first, 1 = write-first.
REQ-006 SHALL have parameter SCR1_INIT_VALUE, default 0, SCR1_WIDTH-bit word written to every location by the init sequence.
REQ-007 SHALL have ports as follows; one clock; reset is synchronous and active-high.
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- rena  in  1  port A read request
- addra  in  [$clog2(SCR1_SIZE)-1:$clog2(SCR1_NBYTES)]  port A word address
- qa  out  SCR1_WIDTH  port A read data
- rvalida  out  1  qa valid this cycle
- renb  in  1  port B read request
- wenb  in  1  port B write request
- webb  in  SCR1_NBYTES  port B byte enables
- addrb  in  same as addra  port B word address
- datab  in  SCR1_WIDTH  port B write data
- qb  out  SCR1_WIDTH  port B read data
- rvalidb  out  1  qb valid this cycle
- init_done  out  1  memory initialised, ports accepted
REQ-008 SHALL fail elaboration on illegal SCR1_WIDTH, SCR1_SIZE or SCR1_RD_LATENCY.

Function
REQ-009 SHALL implement FSM with states INIT and READY; rst forces INIT with init word counter = 0.
REQ-010 In INIT, SHALL write SCR1_INIT_VALUE to word[counter] every cycle and increment the counter; after writing word SCR1_SIZE/SCR1_NBYTES-1, SHALL enter READY on the next edge.
REQ-011 init_done SHALL be 1 only in READY; it rises exactly SCR1_SIZE/SCR1_NBYTES cycles after the first cycle with rst low.
REQ-012 In INIT, rena, renb and wenb SHALL be ignored: no memory effect, rvalida = rvalidb = 0.
REQ-013 In READY, port B write SHALL update only byte lanes i with wenb=1 and webb[i]=1; wenb=1 with webb=0 SHALL leave memory unchanged.
REQ-014 A read accepted at edge N SHALL present data on qa/qb with rvalida/rvalidb = 1 for exactly one cycle after edge N+SCR1_RD_LATENCY-1; back-to-back reads SHALL be accepted every cycle (fully pipelined).
REQ-015 qa/qb SHALL hold the last returned data when no new read completes.
REQ-016 Port B read and write to the same address in one cycle: read-first returns the pre-write word; write-first returns the merged word (enabled lanes from datab, others old).
REQ-017 Port A read to addrb while port B writes SHALL follow the same SCR1_WRITE_FIRST rule as REQ-016.
REQ-018 Reads on both ports to any addresses in the same cycle SHALL both complete with no stall.
REQ-019 Addresses SHALL wrap only within the declared address width; no out-of-range state exists.

Reset
REQ-020 On rst: qa = qb = 0, rvalida = rvalidb = 0, init_done = 0, FSM = INIT, counter = 0; all in-flight read pipeline stages SHALL be flushed.
REQ-021 rst asserted mid-INIT or mid-READY SHALL restart the full init sequence from word 0; memory contents prior to reset are not preserved.

Verification (SCR1_WIDTH=32, SCR1_SIZE=64, 16 words)
REQ-022 Release rst, hold rena/renb = 1 -> rvalid stays 0 for 16 cycles, init_done rises at cycle 16, and a subsequent read of every address returns SCR1_INIT_VALUE.
REQ-023 Write 0xAABBCCDD to word 3 with webb=4'b0101, then read on port A -> 0x00BB00DD (INIT_VALUE 0), rvalida after RD_LATENCY cycles, for latency 1 and 2.
REQ-024 Word 5 = 0x11111111; same-cycle port B write 0x22222222 (webb=4'hF) plus port A and port B reads of word 5 -> both return 0x11111111 with WRITE_FIRST=0, and 0x22222222 with WRITE_FIRST=1.
REQ-025 Continuous alternating reads on both ports for 32 cycles with RD_LATENCY=2 -> one valid result per request, in order, with no gaps.
REQ-026 Assert rst at init count 7, then with a read in flight in READY -> init restarts from 0, init_done low for the full 16 cycles, and the in-flight read never asserts rvalid.

Source files
------------

// File: rtl/scr1_dp_memory_ext.sv
// -----------------------------------------------------------------------------
// scr1_dp_memory_ext
// Dual-port word memory with a self-initialising fill sequence.
//   Port A : read only   (rena, addra -> qa, rvalida)
//   Port B : read/write  (renb, wenb, webb, addrb, datab -> qb, rvalidb)
// After rst every word is loaded with SCR1_INIT_VALUE, one word per cycle.
// Both ports are ignored until init_done is high. Reads are fully pipelined
// with a latency of SCR1_RD_LATENCY (1 or 2) cycles. qa/qb keep the last
// returned word. A same-address read during a port B write returns either the
// old word (read-first) or the merged word (write-first).
//   clk, rst      : single clock, synchronous active-high reset
//   init_done     : high once the fill sequence has completed
// -----------------------------------------------------------------------------
module scr1_dp_memory_ext #(
  parameter int                    SCR1_WIDTH       = 32,
  parameter int                    SCR1_SIZE        = 65536,
  parameter int                    SCR1_NBYTES      = SCR1_WIDTH / 8,
  parameter int                    SCR1_RD_LATENCY  = 1,
  parameter int                    SCR1_WRITE_FIRST = 0,
  parameter logic [SCR1_WIDTH-1:0] SCR1_INIT_VALUE  = {SCR1_WIDTH{1'b0}}
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             rena,
  input  logic [$clog2(SCR1_SIZE)-1:$clog2(SCR1_NBYTES)]   addra,
  output logic [SCR1_WIDTH-1:0]                            qa,
  output logic                                             rvalida,
  input  logic                                             renb,
  input  logic                                             wenb,
  input  logic [SCR1_NBYTES-1:0]                           webb,
  input  logic [$clog2(SCR1_SIZE)-1:$clog2(SCR1_NBYTES)]   addrb,
  input  logic [SCR1_WIDTH-1:0]                            datab,
  output logic [SCR1_WIDTH-1:0]                            qb,
  output logic                                             rvalidb,
  output logic                                             init_done
);

  localparam int WW    = $clog2(SCR1_SIZE) - $clog2(SCR1_NBYTES);
  localparam int WORDS = SCR1_SIZE / SCR1_NBYTES;
  localparam logic [WW-1:0] CNT_ONE  = WW'(1);
  localparam logic [WW-1:0] CNT_LAST = WW'(WORDS - 1);

  // Parameter legality checks, evaluated at elaboration
  if ((SCR1_WIDTH % 8) != 0 || SCR1_WIDTH < 8 || SCR1_WIDTH > 128) begin : g_bad_width
    $error("scr1_dp_memory_ext: SCR1_WIDTH must be a multiple of 8 in 8..128");
  end
  if (SCR1_NBYTES != SCR1_WIDTH / 8) begin : g_bad_nbytes
    $error("scr1_dp_memory_ext: SCR1_NBYTES must equal SCR1_WIDTH/8");
  end
  if ((SCR1_SIZE & (SCR1_SIZE - 1)) != 0 || SCR1_SIZE < 2 * SCR1_NBYTES) begin : g_bad_size
    $error("scr1_dp_memory_ext: SCR1_SIZE must be a power of two >= 2*SCR1_NBYTES");
  end
  if (SCR1_RD_LATENCY != 1 && SCR1_RD_LATENCY != 2) begin : g_bad_lat
    $error("scr1_dp_memory_ext: SCR1_RD_LATENCY must be 1 or 2");
  end

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

  // Replace the enabled byte lanes of old_word with new_word
  function automatic logic [SCR1_WIDTH-1:0] f_merge(
    input logic [SCR1_WIDTH-1:0]  i_old,
    input logic [SCR1_WIDTH-1:0]  i_new,
    input logic [SCR1_NBYTES-1:0] i_be
  );
    logic [SCR1_WIDTH-1:0] v_res;
    v_res = i_old;
    for (int i = 0; i < SCR1_NBYTES; i++) begin
      if (i_be[i]) begin
        v_res[i*8 +: 8] = i_new[i*8 +: 8];
      end
    end
    return v_res;
  endfunction

  state_t                r_state;
  logic [WW-1:0]         r_cnt;
  logic                  r_init_done;
  logic [SCR1_WIDTH-1:0] r_mem [0:WORDS-1];

  logic                  r_a_v1, r_b_v1;
  logic [SCR1_WIDTH-1:0] r_a_d1, r_b_d1;

  logic                  w_ready;
  logic                  w_init_wr;
  logic                  w_b_wr;
  logic                  w_a_rd;
  logic                  w_b_rd;
  logic [SCR1_WIDTH-1:0] w_a_old;
  logic [SCR1_WIDTH-1:0] w_b_old;
  logic [SCR1_WIDTH-1:0] w_b_merged;
  logic [SCR1_WIDTH-1:0] w_a_data;
  logic [SCR1_WIDTH-1:0] w_b_data;

  assign w_ready    = (r_state == ST_READY);
  // rst gates every memory effect so the reset cycle itself is side-effect free
  assign w_init_wr  = !rst && (r_state == ST_INIT);
  assign w_b_wr     = !rst && w_ready && wenb && (|webb);
  assign w_a_rd     = !rst && w_ready && rena;
  assign w_b_rd     = !rst && w_ready && renb;
  assign w_a_old    = r_mem[addra];
  assign w_b_old    = r_mem[addrb];
  assign w_b_merged = f_merge(w_b_old, datab, webb);

  // Read data selection, including the same-address write collision rule
  always_comb begin
    w_a_data = w_a_old;
    w_b_data = w_b_old;
    if (SCR1_WRITE_FIRST != 0 && w_b_wr && (addra == addrb)) begin
      w_a_data = f_merge(w_a_old, datab, webb);
    end else begin
      w_a_data = w_a_old;
    end
    if (SCR1_WRITE_FIRST != 0 && w_b_wr) begin
      w_b_data = w_b_merged;
    end else begin
      w_b_data = w_b_old;
    end
  end

  // Init/ready state machine with the fill counter and init_done flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_cnt       <= {WW{1'b0}};
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_cnt <= r_cnt + CNT_ONE;
          if (r_cnt == CNT_LAST) begin
            r_state     <= ST_READY;
            r_init_done <= 1'b1;
          end else begin
            r_state     <= ST_INIT;
            r_init_done <= 1'b0;
          end
        end
        ST_READY: begin
          r_state     <= ST_READY;
          r_init_done <= 1'b1;
        end
        default: begin
          r_state     <= ST_INIT;
          r_cnt       <= {WW{1'b0}};
          r_init_done <= 1'b0;
        end
      endcase
    end
  end

  // Memory array: fill writes during init, byte-masked port B writes after
  always_ff @(posedge clk) begin
    if (w_init_wr) begin
      r_mem[r_cnt] <= SCR1_INIT_VALUE;
    end else if (w_b_wr) begin
      r_mem[addrb] <= w_b_merged;
    end
  end

  // First read stage; data registers only load on an accepted read
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_v1 <= 1'b0;
      r_b_v1 <= 1'b0;
      r_a_d1 <= {SCR1_WIDTH{1'b0}};
      r_b_d1 <= {SCR1_WIDTH{1'b0}};
    end else begin
      r_a_v1 <= w_a_rd;
      r_b_v1 <= w_b_rd;
      if (w_a_rd) r_a_d1 <= w_a_data;
      if (w_b_rd) r_b_d1 <= w_b_data;
    end
  end

  if (SCR1_RD_LATENCY == 2) begin : g_lat2
    logic                  r_a_v2, r_b_v2;
    logic [SCR1_WIDTH-1:0] r_a_q2, r_b_q2;

    // Second read stage; output data only changes when a read completes
    always_ff @(posedge clk) begin
      if (rst) begin
        r_a_v2 <= 1'b0;
        r_b_v2 <= 1'b0;
        r_a_q2 <= {SCR1_WIDTH{1'b0}};
        r_b_q2 <= {SCR1_WIDTH{1'b0}};
      end else begin
        r_a_v2 <= r_a_v1;
        r_b_v2 <= r_b_v1;
        if (r_a_v1) r_a_q2 <= r_a_d1;
        if (r_b_v1) r_b_q2 <= r_b_d1;
      end
    end

    assign qa      = r_a_q2;
    assign qb      = r_b_q2;
    assign rvalida = r_a_v2;
    assign rvalidb = r_b_v2;
  end else begin : g_lat1
    assign qa      = r_a_d1;
    assign qb      = r_b_d1;
    assign rvalida = r_a_v1;
    assign rvalidb = r_b_v1;
  end

  assign init_done = r_init_done;

endmodule

// File: tb/tb_scr1_dp_memory_ext.sv
// Testbench: two instances share stimulus.
//   dut0: latency 1, read-first,  init value 0
//   dut1: latency 2, write-first, init value 5A5A5A5A
module tb_scr1_dp_memory_ext;

  localparam logic [31:0] INIT1 = 32'h5A5A5A5A;

  logic        clk = 1'b0;
  logic        rst, rena, renb, wenb;
  logic [3:0]  webb;
  logic [5:2]  addra, addrb;
  logic [31:0] datab;

  logic [31:0] qa0, qb0, qa1, qb1;
  logic        rva0, rvb0, done0, rva1, rvb1, done1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  scr1_dp_memory_ext #(
    .SCR1_WIDTH(32), .SCR1_SIZE(64), .SCR1_RD_LATENCY(1),
    .SCR1_WRITE_FIRST(0), .SCR1_INIT_VALUE(32'h0000_0000)
  ) dut0 (
    .clk(clk), .rst(rst), .rena(rena), .addra(addra), .qa(qa0), .rvalida(rva0),
    .renb(renb), .wenb(wenb), .webb(webb), .addrb(addrb), .datab(datab),
    .qb(qb0), .rvalidb(rvb0), .init_done(done0)
  );

  scr1_dp_memory_ext #(
    .SCR1_WIDTH(32), .SCR1_SIZE(64), .SCR1_RD_LATENCY(2),
    .SCR1_WRITE_FIRST(1), .SCR1_INIT_VALUE(INIT1)
  ) dut1 (
    .clk(clk), .rst(rst), .rena(rena), .addra(addra), .qa(qa1), .rvalida(rva1),
    .renb(renb), .wenb(wenb), .webb(webb), .addrb(addrb), .datab(datab),
    .qb(qb1), .rvalidb(rvb1), .init_done(done1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; rena = 1'b1; renb = 1'b1; wenb = 1'b1; webb = 4'hF;
    addra = 4'd0; addrb = 4'd0; datab = 32'hFFFF_FFFF;
    repeat (3) tick();
    total++;
    if ({rva0, rvb0, done0, rva1, rvb1, done1} !== 6'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=000000", {rva0, rvb0, done0, rva1, rvb1, done1});
    end
    total++;
    if ({qa0, qb0, qa1, qb1} !== 128'd0) begin
      bad++; $display("FAIL reset_q got=%h exp=0", {qa0, qb0, qa1, qb1});
    end
  endtask

  // Reads and writes held active through init must have no effect
  task automatic test_init;
    logic exp_done;
    wenb = 1'b1; webb = 4'hF; addrb = 4'd4; datab = 32'hFFFF_FFFF;
    rena = 1'b1; renb = 1'b1;
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_done = (k == 16);
      total++;
      if ({done0, done1} !== {exp_done, exp_done}) begin
        bad++; $display("FAIL init_done cycle=%0d got=%b exp=%b", k, {done0, done1}, {exp_done, exp_done});
      end
      total++;
      if ({rva0, rvb0, rva1, rvb1} !== 4'b0) begin
        bad++; $display("FAIL init_rvalid cycle=%0d got=%b exp=0000", k, {rva0, rvb0, rva1, rvb1});
      end
    end
    rena = 1'b0; renb = 1'b0; wenb = 1'b0;
  endtask

  task automatic test_read_all;
    for (int i = 0; i < 16; i++) begin
      addra = 4'(i); addrb = 4'(15 - i); rena = 1'b1; renb = 1'b1;
      tick();
      rena = 1'b0; renb = 1'b0;
      total++;
      if ({rva0, rvb0, rva1, rvb1} !== 4'b1100 || qa0 !== 32'd0 || qb0 !== 32'd0) begin
        bad++; $display("FAIL readall_l1 addr=%0d got=%b %h %h exp=1100 0 0", i, {rva0, rvb0, rva1, rvb1}, qa0, qb0);
      end
      tick();
      total++;
      if ({rva0, rvb0, rva1, rvb1} !== 4'b0011 || qa1 !== INIT1 || qb1 !== INIT1) begin
        bad++; $display("FAIL readall_l2 addr=%0d got=%b %h %h exp=0011 %h", i, {rva0, rvb0, rva1, rvb1}, qa1, qb1, INIT1);
      end
    end
  endtask

  task automatic test_byte_write;
    wenb = 1'b1; webb = 4'b0101; addrb = 4'd3; datab = 32'hAABB_CCDD;
    tick();
    wenb = 1'b0;
    rena = 1'b1; addra = 4'd3;
    tick();
    rena = 1'b0;
    total++;
    if (rva0 !== 1'b1 || qa0 !== 32'h00BB_00DD || rva1 !== 1'b0) begin
      bad++; $display("FAIL bytewr_l1 got=%b %h %b exp=1 00bb00dd 0", rva0, qa0, rva1);
    end
    tick();
    total++;
    if (rva0 !== 1'b0 || qa0 !== 32'h00BB_00DD) begin
      bad++; $display("FAIL bytewr_hold got=%b %h exp=0 00bb00dd", rva0, qa0);
    end
    total++;
    if (rva1 !== 1'b1 || qa1 !== 32'h5ABB_5ADD) begin
      bad++; $display("FAIL bytewr_l2 got=%b %h exp=1 5abb5add", rva1, qa1);
    end
    tick();
    total++;
    if (rva1 !== 1'b0 || qa1 !== 32'h5ABB_5ADD) begin
      bad++; $display("FAIL bytewr_l2_hold got=%b %h exp=0 5abb5add", rva1, qa1);
    end
    // write with no lanes enabled must leave the word alone
    wenb = 1'b1; webb = 4'b0000; addrb = 4'd3; datab = 32'hFFFF_FFFF;
    tick();
    wenb = 1'b0; renb = 1'b1;
    tick();
    renb = 1'b0;
    total++;
    if (rvb0 !== 1'b1 || qb0 !== 32'h00BB_00DD) begin
      bad++; $display("FAIL nolane_l1 got=%b %h exp=1 00bb00dd", rvb0, qb0);
    end
    tick();
    total++;
    if (rvb1 !== 1'b1 || qb1 !== 32'h5ABB_5ADD) begin
      bad++; $display("FAIL nolane_l2 got=%b %h exp=1 5abb5add", rvb1, qb1);
    end
  endtask

  task automatic test_collision;
    wenb = 1'b1; webb = 4'hF; addrb = 4'd5; datab = 32'h1111_1111;
    tick();
    datab = 32'h2222_2222; addra = 4'd5; rena = 1'b1; renb = 1'b1;
    tick();
    wenb = 1'b0; rena = 1'b0; renb = 1'b0;
    total++;
    if ({rva0, rvb0} !== 2'b11 || qa0 !== 32'h1111_1111 || qb0 !== 32'h1111_1111) begin
      bad++; $display("FAIL coll_readfirst got=%b %h %h exp=11 11111111", {rva0, rvb0}, qa0, qb0);
    end
    total++;
    if ({rva1, rvb1} !== 2'b00) begin
      bad++; $display("FAIL coll_l2_early got=%b exp=00", {rva1, rvb1});
    end
    tick();
    total++;
    if ({rva1, rvb1} !== 2'b11 || qa1 !== 32'h2222_2222 || qb1 !== 32'h2222_2222) begin
      bad++; $display("FAIL coll_writefirst got=%b %h %h exp=11 22222222", {rva1, rvb1}, qa1, qb1);
    end
    rena = 1'b1;
    tick();
    rena = 1'b0;
    total++;
    if (rva0 !== 1'b1 || qa0 !== 32'h2222_2222) begin
      bad++; $display("FAIL coll_after_l1 got=%b %h exp=1 22222222", rva0, qa0);
    end
    tick();
    total++;
    if (rva1 !== 1'b1 || qa1 !== 32'h2222_2222) begin
      bad++; $display("FAIL coll_after_l2 got=%b %h exp=1 22222222", rva1, qa1);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0]  aa [32];
    logic [3:0]  bb [32];
    logic        exp_v;
    logic [31:0] ea, eb;
    int          cnt1;
    for (int i = 8; i < 16; i++) begin
      wenb = 1'b1; webb = 4'hF; addrb = 4'(i); datab = 32'hC0DE_0000 + 32'(i);
      tick();
    end
    wenb = 1'b0;
    for (int j = 0; j < 32; j++) begin
      aa[j] = 4'(8 + ((j * 3) % 8));
      bb[j] = 4'(8 + ((j * 5 + 1) % 8));
    end
    cnt1 = 0;
    for (int j = 0; j < 34; j++) begin
      if (j < 32) begin
        rena = 1'b1; renb = 1'b1; addra = aa[j]; addrb = bb[j];
      end else begin
        rena = 1'b0; renb = 1'b0;
      end
      tick();
      // latency 1 instance
      exp_v = (j < 32);
      ea = 32'hC0DE_0000 + {28'd0, aa[(j < 32) ? j : 31]};
      eb = 32'hC0DE_0000 + {28'd0, bb[(j < 32) ? j : 31]};
      total++;
      if ({rva0, rvb0} !== {exp_v, exp_v} || qa0 !== ea || qb0 !== eb) begin
        bad++; $display("FAIL b2b_l1 cyc=%0d got=%b %h %h exp=%b %h %h", j, {rva0, rvb0}, qa0, qb0, {exp_v, exp_v}, ea, eb);
      end
      // latency 2 instance
      exp_v = (j >= 1) && (j <= 32);
      if (j >= 1) begin
        ea = 32'hC0DE_0000 + {28'd0, aa[(j <= 32) ? j - 1 : 31]};
        eb = 32'hC0DE_0000 + {28'd0, bb[(j <= 32) ? j - 1 : 31]};
        total++;
        if ({rva1, rvb1} !== {exp_v, exp_v} || qa1 !== ea || qb1 !== eb) begin
          bad++; $display("FAIL b2b_l2 cyc=%0d got=%b %h %h exp=%b %h %h", j, {rva1, rvb1}, qa1, qb1, {exp_v, exp_v}, ea, eb);
        end
      end else begin
        total++;
        if ({rva1, rvb1} !== 2'b00) begin
          bad++; $display("FAIL b2b_l2_first got=%b exp=00", {rva1, rvb1});
        end
      end
      if (rva1 === 1'b1) cnt1++;
    end
    total++;
    if (cnt1 != 32) begin
      bad++; $display("FAIL b2b_count got=%0d exp=32", cnt1);
    end
  endtask

  task automatic test_reset_mid;
    rst = 1'b1;
    tick();
    total++;
    if ({rva0, rvb0, done0, rva1, rvb1, done1} !== 6'b0 || {qa0, qb0, qa1, qb1} !== 128'd0) begin
      bad++; $display("FAIL rst_ready got=%b %h exp=000000 0", {rva0, rvb0, done0, rva1, rvb1, done1}, {qa0, qb0, qa1, qb1});
    end
    rst = 1'b0;
    repeat (7) tick();
    total++;
    if ({done0, done1} !== 2'b00) begin
      bad++; $display("FAIL rst_mid_init7 got=%b exp=00", {done0, done1});
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      total++;
      if ({done0, done1} !== {2{k == 16}}) begin
        bad++; $display("FAIL restart_done cycle=%0d got=%b exp=%b", k, {done0, done1}, {2{k == 16}});
      end
    end
    // word 10 held C0DE000A before reset; refill must overwrite it
    rena = 1'b1; addra = 4'd10;
    tick();
    rena = 1'b0;
    total++;
    if (rva0 !== 1'b1 || qa0 !== 32'd0 || rva1 !== 1'b0) begin
      bad++; $display("FAIL refill_l1 got=%b %h %b exp=1 0 0", rva0, qa0, rva1);
    end
    rst = 1'b1;
    tick();
    total++;
    if (rva1 !== 1'b0 || qa1 !== 32'd0) begin
      bad++; $display("FAIL flush_rst got=%b %h exp=0 0", rva1, qa1);
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if ({rva0, rva1, done0, done1} !== 4'b0) begin
        bad++; $display("FAIL flush_after cycle=%0d got=%b exp=0000", k, {rva0, rva1, done0, done1});
      end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_read_all();
    test_byte_write();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
